gate_stim_seq: RTL and testbench

Upstream stimulus sequencer and response capture for the four-input `gate` network. It drives all 16 input combinations onto `{a,b,c,d}` in ascending order. Each vector is held for a programmable number of cycles, and the single-bit `out` is sampled back into a 16-bit truth-table word. When the sweep finishes, the captured word is compared against an expected word. The block replaces free-running testbench stimulus with a clocked, handshaked sweep.

---
 rtl/gate_seq_pkg.sv | 16 +
 rtl/gate_hold_timer.sv | 36 +++
 rtl/gate_stim_seq.sv | 122 ++++++++++++
 tb/tb_gate_stim_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/gate_seq_pkg.sv
// Shared constants for the gate stimulus sequencer: FSM encoding, sweep sizes
// and the golden truth table of the current gate network.
package gate_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int NVEC  = 16;
  localparam int VEC_W = 4;
  localparam int TT_W  = 16;

  // out = (a|b) & ~(~b & ~(c|d)), bit i is the response to {a,b,c,d} = i
  localparam logic [TT_W-1:0] GATE_TT = 16'hFEF0;

endpackage

// File: rtl/gate_hold_timer.sv
// Per-vector hold counter: counts while enabled, flags the last hold cycle
// and wraps to zero on it.
module gate_hold_timer #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] hold_cnt,
  output logic       last
);

  logic [3:0] hold_cnt_r;

  assign hold_cnt = hold_cnt_r;
  assign last     = (hold_cnt_r == 4'(HOLD_CYCLES - 1));

  // hold counter with clear priority over count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt_r <= 4'd0;
    end else if (clr) begin
      hold_cnt_r <= 4'd0;
    end else if (en) begin
      if (last) begin
        hold_cnt_r <= 4'd0;
      end else begin
        hold_cnt_r <= hold_cnt_r + 4'd1;
      end
    end else begin
      hold_cnt_r <= hold_cnt_r;
    end
  end

endmodule

// File: rtl/gate_stim_seq.sv
// Sweeps all 16 {a,b,c,d} vectors into the gate network, captures its output
// into a truth-table word and compares it with a golden word at the end.
module gate_stim_seq
  import gate_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  // golden word; "expect" is a reserved word in SystemVerilog
  input  logic [TT_W-1:0]  expected,
  input  logic             gate_out,
  output logic [VEC_W-1:0] vec,
  output logic             busy,
  output logic             done,
  output logic [TT_W-1:0]  truth_table,
  output logic             match,
  output logic [4:0]       mismatch_cnt
);

  logic [1:0]       state_r;
  logic [3:0]       idx_r;
  logic [VEC_W-1:0] vec_r;
  logic             busy_r;
  logic             done_r;
  logic [TT_W-1:0]  tt_r;
  logic             match_r;
  logic [4:0]       mcnt_r;

  logic             run_s;
  logic             last_s;
  logic [3:0]       hold_cnt_s;
  logic [TT_W-1:0]  diff_s;
  logic [4:0]       pop_s;

  assign run_s = (state_r == ST_RUN);

  gate_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (!run_s),
    .en       (run_s),
    .hold_cnt (hold_cnt_s),
    .last     (last_s)
  );

  // mismatch popcount between captured and golden words
  always_comb begin
    diff_s = tt_r ^ expected;
    pop_s  = 5'd0;
    for (int i = 0; i < NVEC; i++) begin
      pop_s = pop_s + {4'd0, diff_s[i]};
    end
  end

  // sweep FSM with capture and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      idx_r   <= 4'd0;
      vec_r   <= {VEC_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      tt_r    <= {TT_W{1'b0}};
      match_r <= 1'b0;
      mcnt_r  <= 5'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r <= ST_RUN;
            idx_r   <= 4'd0;
            vec_r   <= {VEC_W{1'b0}};
            tt_r    <= {TT_W{1'b0}};
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
            vec_r   <= {VEC_W{1'b0}};
          end
        end
        ST_RUN: begin
          if (last_s) begin
            tt_r[idx_r] <= gate_out;
            idx_r       <= idx_r + 4'd1;
            if (idx_r == 4'd15) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
              vec_r   <= {VEC_W{1'b0}};
            end else begin
              vec_r   <= idx_r + 4'd1;
            end
          end else begin
            vec_r <= idx_r;
          end
        end
        ST_DONE: begin
          match_r <= (tt_r == expected);
          mcnt_r  <= pop_s;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          vec_r   <= {VEC_W{1'b0}};
        end
      endcase
    end
  end

  assign vec          = vec_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign truth_table  = tt_r;
  assign match        = match_r;
  assign mismatch_cnt = mcnt_r;

endmodule

// File: tb/tb_gate_stim_seq.sv
// Bench for gate_stim_seq: three instances (hold 1, 2, 15) driven from a
// sweep table plus hand-written reset / busy-start sequences, scoreboarded.
module tb_gate_stim_seq;
  import gate_seq_pkg::*;

  localparam int NI = 3;

  typedef struct {
    int              g;
    logic [15:0]     e;
  } row_t;

  typedef struct {
    int              inst;
    logic [15:0]     tt;
    logic            m;
    logic [4:0]      cnt;
    int              lat;
    longint          t0;
  } sb_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] expected;
  logic        start_a [NI];
  logic        gout_a  [NI];
  logic [3:0]  vec_a   [NI];
  logic        busy_a  [NI];
  logic        done_a  [NI];
  logic [15:0] tt_a    [NI];
  logic        match_a [NI];
  logic [4:0]  cnt_a   [NI];

  logic        pend    [NI];
  logic        pm      [NI];
  logic [4:0]  pc      [NI];

  sb_t  sbq[$];
  row_t tbl[6];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic int hold_of(input int g);
    case (g)
      0:       return 1;
      1:       return 2;
      default: return 15;
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign gout_a[g] = (vec_a[g][3] | vec_a[g][2]) &
                       ~(~vec_a[g][2] & ~(vec_a[g][1] | vec_a[g][0]));
    gate_stim_seq #(.HOLD_CYCLES((g == 0) ? 1 : (g == 1) ? 2 : 15)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start_a[g]),
      .expected     (expected),
      .gate_out     (gout_a[g]),
      .vec          (vec_a[g]),
      .busy         (busy_a[g]),
      .done         (done_a[g]),
      .truth_table  (tt_a[g]),
      .match        (match_a[g]),
      .mismatch_cnt (cnt_a[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // caller is at a negedge; start is high across exactly one posedge
  task automatic kick(input int g, input logic [15:0] e);
    sb_t r;
    expected   = e;
    start_a[g] = 1'b1;
    r.inst = g;
    r.tt   = GATE_TT;
    r.m    = (GATE_TT == e);
    r.cnt  = 5'($countones(GATE_TT ^ e));
    r.lat  = 16 * hold_of(g) + 1;
    r.t0   = longint'($time) + 64'sd5;
    sbq.push_back(r);
    @(negedge clk);
    start_a[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g, input int budget);
    int n;
    n = 0;
    while (busy_a[g] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, busy_a[g]}, 32'd0);
  endtask

  function automatic logic [31:0] outs(input int g);
    return {4'd0, vec_a[g], busy_a[g], done_a[g], tt_a[g], match_a[g], cnt_a[g]};
  endfunction

  // output monitor: vec stepping, done latency, results one cycle later
  always @(posedge clk) begin
    sb_t    r;
    longint k;
    #2;
    for (int g = 0; g < NI; g++) begin
      if (pend[g]) begin
        check("match", {31'd0, match_a[g]}, {31'd0, pm[g]});
        check("mismatch_cnt", {27'd0, cnt_a[g]}, {27'd0, pc[g]});
        check("busy_fall", {31'd0, busy_a[g]}, 32'd0);
        pend[g] = 1'b0;
      end
      if (done_a[g]) begin
        if (sbq.size() == 0 || sbq[0].inst != g) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          r = sbq.pop_front();
          k = (longint'($time) - 64'sd2 - r.t0) / 64'sd10 + 64'sd1;
          check("done_latency", 32'(k), 32'(r.lat));
          check("truth_table", {16'd0, tt_a[g]}, {16'd0, r.tt});
          pm[g]   = r.m;
          pc[g]   = r.cnt;
          pend[g] = 1'b1;
        end
      end else if (busy_a[g] && sbq.size() != 0 && sbq[0].inst == g) begin
        k = (longint'($time) - 64'sd2 - sbq[0].t0) / 64'sd10 + 64'sd1;
        check("vec_step", {28'd0, vec_a[g]}, 32'((k - 64'sd1) / longint'(hold_of(g))));
      end
    end
  end

  initial begin
    int n;
    for (int g = 0; g < NI; g++) begin
      start_a[g] = 1'b1;
      pend[g]    = 1'b0;
    end
    rst_n    = 1'b0;
    expected = 16'h0000;
    tbl[0] = '{1, 16'hFEF0};
    tbl[1] = '{1, 16'h0F0F};
    tbl[2] = '{0, 16'hFEF0};
    tbl[3] = '{2, 16'hFEF0};
    tbl[4] = '{0, 16'h0000};
    tbl[5] = '{1, 16'hFFFF};

    // reset with start held high
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) check("reset_outs", outs(g), 32'd0);
    for (int g = 0; g < NI; g++) start_a[g] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // table-driven sweeps
    for (int i = 0; i < 6; i++) begin
      kick(tbl[i].g, tbl[i].e);
      wait_idle(tbl[i].g, 300);
      @(negedge clk);
    end

    // start pulses mid-sweep are ignored, then back-to-back restart
    kick(1, GATE_TT);
    for (int c = 2; c <= 36; c++) begin
      start_a[1] = (c == 5 || c == 20);
      @(negedge clk);
      if (!busy_a[1]) break;
    end
    start_a[1] = 1'b0;
    wait_idle(1, 100);
    kick(1, GATE_TT);
    check("tt_cleared", {16'd0, tt_a[1]}, 32'd0);
    wait_idle(1, 100);
    @(negedge clk);

    // reset in the middle of a sweep
    kick(1, GATE_TT);
    n = 0;
    while (vec_a[1] != 4'd7 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reached_idx7", {28'd0, vec_a[1]}, 32'd7);
    rst_n = 1'b0;
    sbq.delete();
    @(negedge clk);
    check("midreset_outs", outs(1), 32'd0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("no_done_after_abort", {31'd0, busy_a[1]}, 32'd0);
    kick(1, GATE_TT);
    wait_idle(1, 100);
    @(negedge clk);

    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
